// File: rtl/elevator_pkg.sv
// elevator_pkg: shared floor geometry and FSM state encoding for the elevator dispatcher.
//   NUM_FLOORS - number of served floors (0..6)
//   FLOOR_W    - width of a floor index
//   state_t    - dispatcher FSM states
package elevator_pkg;
  localparam int NUM_FLOORS = 7;
  localparam int FLOOR_W = 3;
  typedef enum logic [1:0] {IDLE, SERV_UP, SERV_DN} state_t;
endpackage

// File: rtl/elevator_req_search.sv
// elevator_req_search: combinational search of the pending-floor vector relative to the car.
//   pend    in  pending requests per floor (all sources ORed)
//   floor   in  current car floor
//   above   out some request at a floor strictly above floor
//   below   out some request at a floor strictly below floor
//   near_up out nearest request lies at or above floor (distance tie resolves up)
module elevator_req_search
  import elevator_pkg::*;
(
  input  logic [NUM_FLOORS-1:0] pend,
  input  logic [FLOOR_W-1:0]    floor,
  output logic                  above,
  output logic                  below,
  output logic                  near_up
);
  logic [3:0] d_up, d_dn;
  // 4'hf marks "no request on that side"; it exceeds every real distance.
  always_comb begin
    above = 1'b0;
    below = 1'b0;
    d_up = 4'hf;
    d_dn = 4'hf;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend[i] && i > int'(floor)) above = 1'b1;
      if (pend[i] && i < int'(floor)) below = 1'b1;
      if (pend[i] && i >= int'(floor) && 4'(i - int'(floor)) < d_up) d_up = 4'(i - int'(floor));
      if (pend[i] && i < int'(floor) && 4'(int'(floor) - i) < d_dn) d_dn = 4'(int'(floor) - i);
    end
    near_up = d_up <= d_dn;
  end
endmodule

// File: rtl/elevator_dispatcher.sv
// elevator_dispatcher: latches hall/car requests and picks the car's next travel direction.
//   clk, reset        clock; synchronous active-high reset
//   hall_up_req[7]    hall up-button pulses (floor 6 ignored)
//   hall_dn_req[7]    hall down-button pulses (floor 0 ignored)
//   car_req[7]        in-car button pulses
//   current_floor[3]  car position 0..6 (7 is ignored)
//   current_up_ndown  car travel direction, 1 = up
//   car_arrived       one-cycle pulse when the car stops at current_floor
//   queue_status[7]   registered OR of all pending requests per floor
//   queue_empty       registered "nothing pending"
//   next_up_ndown     registered direction to take next, 1 = up
//   up_lamp[7]        pending hall-up requests
//   dn_lamp[7]        pending hall-down requests
// Optional: DISP_STARVE_GUARD_EN forces a reversal after STARVE_LIMIT arrivals in one direction.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_dn_req,
  input  logic [NUM_FLOORS-1:0] car_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  current_up_ndown,
  input  logic                  car_arrived,
  output logic [NUM_FLOORS-1:0] queue_status,
  output logic                  queue_empty,
  output logic                  next_up_ndown,
  output logic [NUM_FLOORS-1:0] up_lamp,
  output logic [NUM_FLOORS-1:0] dn_lamp
);
  logic [NUM_FLOORS-1:0] up_pend, dn_pend, car_pend, pend, hit, up_clr, dn_clr, up_nx, dn_nx, car_nx;
  logic above, below, near_up, starve, nud;
  state_t state, nxt;
  assign pend = up_pend | dn_pend | car_pend;
  elevator_req_search u_search (
    .pend    (pend),
    .floor   (current_floor),
    .above   (above),
    .below   (below),
    .near_up (near_up)
  );
  assign hit = (car_arrived && current_floor != 3'd7) ? 7'd1 << current_floor : '0;
  // The opposite hall call is also served when the car turns around here.
  assign up_clr = (current_up_ndown || !below) ? hit : '0;
  assign dn_clr = (!current_up_ndown || !above) ? hit : '0;
  // New requests are ORed in after clearing so a same-cycle set wins.
  assign up_nx = (up_pend & ~up_clr) | (hall_up_req & 7'h3f);
  assign dn_nx = (dn_pend & ~dn_clr) | (hall_dn_req & 7'h7e);
  assign car_nx = (car_pend & ~hit) | car_req;
  assign up_lamp = up_pend;
  assign dn_lamp = dn_pend;
`ifdef DISP_STARVE_GUARD_EN
  logic [3:0] cnt;
  assign starve = car_arrived && (int'(cnt) + 1 >= STARVE_LIMIT);
  always_ff @(posedge clk)
    if (reset || nxt != state) cnt <= '0;
    else if (car_arrived && state != IDLE && cnt != 4'hf) cnt <= cnt + 4'd1;
`else
  // No guard: a negative limit is never configured, so this is constant 0.
  assign starve = STARVE_LIMIT < 0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ~|pend ? IDLE : near_up ? SERV_UP : SERV_DN;
      SERV_UP: nxt = (above && !(starve && below)) ? SERV_UP : below ? SERV_DN : IDLE;
      SERV_DN: nxt = (below && !(starve && above)) ? SERV_DN : above ? SERV_UP : IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign nud = nxt == SERV_UP;
  always_ff @(posedge clk)
    if (reset) begin
      up_pend <= '0;
      dn_pend <= '0;
      car_pend <= '0;
      queue_status <= '0;
      queue_empty <= 1'b1;
      state <= IDLE;
      next_up_ndown <= 1'b0;
    end else begin
      up_pend <= up_nx;
      dn_pend <= dn_nx;
      car_pend <= car_nx;
      queue_status <= up_nx | dn_nx | car_nx;
      queue_empty <= ~|(up_nx | dn_nx | car_nx);
      state <= nxt;
      next_up_ndown <= nud;
    end
endmodule

// File: tb/tb_elevator_dispatcher.sv
// tb_elevator_dispatcher: table-driven directed checks of elevator_dispatcher.
module tb_elevator_dispatcher;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] hall_up_req = '0, hall_dn_req = '0, car_req = '0;
  logic [2:0] current_floor = '0;
  logic current_up_ndown = 1'b0, car_arrived = 1'b0;
  logic [6:0] queue_status, up_lamp, dn_lamp;
  logic queue_empty, next_up_ndown;
  int checks = 0, failures = 0;

  typedef struct {
    logic [6:0] hu, hd, car;
    logic [2:0] fl;
    logic dir, arr;
    logic [6:0] qs;
    logic emp, nud;
    logic [6:0] ul, dl;
  } vec_t;
  vec_t tbl[17];

  elevator_dispatcher #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .reset(reset), .hall_up_req(hall_up_req), .hall_dn_req(hall_dn_req),
    .car_req(car_req), .current_floor(current_floor), .current_up_ndown(current_up_ndown),
    .car_arrived(car_arrived), .queue_status(queue_status), .queue_empty(queue_empty),
    .next_up_ndown(next_up_ndown), .up_lamp(up_lamp), .dn_lamp(dn_lamp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] hu, hd, car, input logic [2:0] fl, input logic dir, arr);
    hall_up_req = hu; hall_dn_req = hd; car_req = car;
    current_floor = fl; current_up_ndown = dir; car_arrived = arr;
    @(posedge clk); #1;
    hall_up_req = '0; hall_dn_req = '0; car_req = '0; car_arrived = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [6:0] qs, input logic emp, nud, input logic [6:0] ul, dl);
    chk({tag, ".queue_status"}, queue_status, qs);
    chk({tag, ".queue_empty"}, 7'(queue_empty), 7'(emp));
    chk({tag, ".next_up_ndown"}, 7'(next_up_ndown), 7'(nud));
    chk({tag, ".up_lamp"}, up_lamp, ul);
    chk({tag, ".dn_lamp"}, dn_lamp, dl);
  endtask

  initial begin
    //             hu     hd     car    fl  dir  arr  | qs     emp  nud  ul     dl
    tbl[0]  = '{7'h00, 7'h00, 7'h00, 3'd0, 1'b0, 1'b0, 7'h00, 1'b1, 1'b0, 7'h00, 7'h00};
    tbl[1]  = '{7'h00, 7'h00, 7'h10, 3'd0, 1'b0, 1'b0, 7'h10, 1'b0, 1'b0, 7'h00, 7'h00};
    tbl[2]  = '{7'h00, 7'h00, 7'h00, 3'd0, 1'b0, 1'b0, 7'h10, 1'b0, 1'b1, 7'h00, 7'h00};
    tbl[3]  = '{7'h08, 7'h01, 7'h00, 3'd1, 1'b1, 1'b0, 7'h18, 1'b0, 1'b1, 7'h08, 7'h00};
    tbl[4]  = '{7'h40, 7'h04, 7'h00, 3'd3, 1'b1, 1'b1, 7'h14, 1'b0, 1'b1, 7'h00, 7'h04};
    tbl[5]  = '{7'h00, 7'h00, 7'h00, 3'd4, 1'b1, 1'b1, 7'h04, 1'b0, 1'b0, 7'h00, 7'h04};
    tbl[6]  = '{7'h00, 7'h00, 7'h00, 3'd3, 1'b0, 1'b0, 7'h04, 1'b0, 1'b0, 7'h00, 7'h04};
    tbl[7]  = '{7'h00, 7'h00, 7'h01, 3'd2, 1'b0, 1'b1, 7'h01, 1'b0, 1'b0, 7'h00, 7'h00};
    tbl[8]  = '{7'h00, 7'h00, 7'h00, 3'd2, 1'b0, 1'b0, 7'h01, 1'b0, 1'b0, 7'h00, 7'h00};
    tbl[9]  = '{7'h00, 7'h00, 7'h00, 3'd0, 1'b0, 1'b1, 7'h00, 1'b1, 1'b0, 7'h00, 7'h00};
    tbl[10] = '{7'h00, 7'h00, 7'h22, 3'd3, 1'b0, 1'b0, 7'h22, 1'b0, 1'b0, 7'h00, 7'h00};
    tbl[11] = '{7'h00, 7'h00, 7'h00, 3'd3, 1'b0, 1'b0, 7'h22, 1'b0, 1'b1, 7'h00, 7'h00};
    tbl[12] = '{7'h08, 7'h00, 7'h00, 3'd3, 1'b1, 1'b1, 7'h2a, 1'b0, 1'b1, 7'h08, 7'h00};
    tbl[13] = '{7'h00, 7'h00, 7'h00, 3'd3, 1'b1, 1'b1, 7'h22, 1'b0, 1'b1, 7'h00, 7'h00};
    tbl[14] = '{7'h00, 7'h02, 7'h00, 3'd5, 1'b1, 1'b1, 7'h02, 1'b0, 1'b0, 7'h00, 7'h02};
    tbl[15] = '{7'h00, 7'h00, 7'h00, 3'd7, 1'b0, 1'b1, 7'h02, 1'b0, 1'b0, 7'h00, 7'h02};
    tbl[16] = '{7'h00, 7'h00, 7'h00, 3'd1, 1'b0, 1'b1, 7'h00, 1'b1, 1'b0, 7'h00, 7'h00};
    drive('0, '0, '0, 3'd0, 1'b0, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].hu, tbl[i].hd, tbl[i].car, tbl[i].fl, tbl[i].dir, tbl[i].arr);
      chk_all($sformatf("vec%0d", i), tbl[i].qs, tbl[i].emp, tbl[i].nud, tbl[i].ul, tbl[i].dl);
    end
    // Serving up to floor 5 with a lower down call pending turns the car around.
    drive(7'h20, '0, '0, 3'd2, 1'b1, 1'b0);
    drive('0, '0, '0, 3'd2, 1'b1, 1'b0);
    chk("turn.go_up", 7'(next_up_ndown), 7'd1);
    drive('0, 7'h02, '0, 3'd3, 1'b1, 1'b0);
    chk("turn.keep_up", 7'(next_up_ndown), 7'd1);
    chk("turn.dn_set", dn_lamp, 7'h02);
    drive('0, '0, '0, 3'd5, 1'b1, 1'b1);
    chk("turn.up_clr", up_lamp, 7'h00);
    chk("turn.dn_keep", dn_lamp, 7'h02);
    chk("turn.reverse", 7'(next_up_ndown), 7'd0);
    // Reset in the middle of operation drops everything, including same-cycle requests.
    drive(7'h01, '0, 7'h48, 3'd0, 1'b0, 1'b0);
    chk_all("pre_rst", 7'h4b, 1'b0, 1'b1, 7'h01, 7'h02);
    reset = 1'b1;
    drive('0, '0, 7'h04, 3'd0, 1'b0, 1'b0);
    chk_all("rst", 7'h00, 1'b1, 1'b0, 7'h00, 7'h00);
    reset = 1'b0;
    drive('0, '0, '0, 3'd0, 1'b0, 1'b0);
    chk_all("post_rst", 7'h00, 1'b1, 1'b0, 7'h00, 7'h00);
`ifdef DISP_STARVE_GUARD_EN
    drive(7'h1c, '0, 7'h01, 3'd1, 1'b1, 1'b0);
    drive('0, '0, '0, 3'd1, 1'b1, 1'b0);
    chk("starve.up", 7'(next_up_ndown), 7'd1);
    drive('0, '0, '0, 3'd2, 1'b1, 1'b1);
    chk("starve.first", 7'(next_up_ndown), 7'd1);
    drive('0, '0, '0, 3'd3, 1'b1, 1'b1);
    chk("starve.forced_dn", 7'(next_up_ndown), 7'd0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
